// File: rtl/decode_stage.sv
// decode_stage: turns a PA request into a root-table walk descriptor.
// One-cycle elastic stage with an output register and one skid slot.
module decode_stage #(
    parameter int PIPELINE_SLAVE_DATA_WIDTH  = 66,
    parameter int PIPELINE_MASTER_DATA_WIDTH = 136
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  decode_slave_valid_i,
    output logic                                  decode_slave_ready_o,
    input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  decode_slave_data_i,
    output logic                                  decode_master_valid_o,
    input  logic                                  decode_master_ready_i,
    output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] decode_master_data_o,
    input  logic [1:0]                            mmpt_mode_i,
    input  logic [43:0]                           mmpt_ppn_i,
    input  logic                                  decode_ctrl_flush_i,
    output logic                                  decode_ctrl_busy_o,
    output logic [15:0]                           decode_fault_count_o
);

    localparam int MW = PIPELINE_MASTER_DATA_WIDTH;

    generate
        if (PIPELINE_SLAVE_DATA_WIDTH != 66) begin : g_bad_slave_w
            $error("PIPELINE_SLAVE_DATA_WIDTH must be 66");
        end
        if (PIPELINE_MASTER_DATA_WIDTH != 136) begin : g_bad_master_w
            $error("PIPELINE_MASTER_DATA_WIDTH must be 136");
        end
    endgenerate

    logic [63:0]   pa;
    logic [1:0]    acc;
    logic [8:0]    index;
    logic [1:0]    levels;
    logic          bypass;
    logic          range_bad;
    logic          fault;
    logic [1:0]    cause;
    logic [63:0]   root;
    logic [MW-1:0] desc;

    logic          out_valid;
    logic          skid_valid;
    logic          ready_en;
    logic [MW-1:0] out_data;
    logic [MW-1:0] skid_data;
    logic [15:0]   fault_cnt;
    logic          accept;
    logic          consume;

    // Decode the incoming request against the live CSR values
    always_comb begin
        pa        = decode_slave_data_i[63:0];
        acc       = decode_slave_data_i[65:64];
        index     = 9'd0;
        levels    = 2'd0;
        bypass    = 1'b0;
        range_bad = 1'b0;
        unique case (1'b1)
            mmpt_mode_i == 2'b00: begin
                bypass = 1'b1;
            end
            mmpt_mode_i == 2'b01: begin
                levels    = 2'd2;
                index     = pa[42:34];
                range_bad = |pa[63:43];
            end
            mmpt_mode_i == 2'b10: begin
                levels    = 2'd3;
                index     = pa[51:43];
                range_bad = |pa[63:52];
            end
            default: ;
        endcase
        if (mmpt_mode_i == 2'b11) begin
            cause = 2'b10;
        end else if (acc == 2'b11) begin
            cause = 2'b11;
        end else if (range_bad) begin
            cause = 2'b01;
        end else begin
            cause = 2'b00;
        end
        fault = |cause;
        root  = {8'b0, mmpt_ppn_i, 12'b0} | {52'b0, index, 3'b0};
        if (bypass || fault) begin
            root   = 64'd0;
            levels = 2'd0;
        end
        if (fault) begin
            bypass = 1'b0;
        end
        desc = {cause, fault, bypass, levels, acc, root, pa};
    end

    assign accept  = decode_slave_valid_i & decode_slave_ready_o;
    assign consume = out_valid & decode_master_ready_i;

    assign decode_slave_ready_o  = ready_en & ~skid_valid & ~decode_ctrl_flush_i;
    assign decode_master_valid_o = out_valid;
    assign decode_master_data_o  = out_data;
    assign decode_ctrl_busy_o    = out_valid | skid_valid;
    assign decode_fault_count_o  = fault_cnt;

    // Keep ready low until the first edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Output and skid registers: fill, drain in order, flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (decode_ctrl_flush_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume && skid_valid) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
        end else if (accept && (consume || !out_valid)) begin
            out_valid <= 1'b1;
            out_data  <= desc;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= desc;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Count faulted descriptors leaving the stage, saturating
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_cnt <= 16'd0;
        end else if (consume && out_data[133] && fault_cnt != 16'hFFFF) begin
            fault_cnt <= fault_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors and handshake sequences
// for the decode_stage descriptor builder.
module tb_decode_stage;

    logic         clk;
    logic         rst_ni;
    logic         svalid;
    logic         sready;
    logic [65:0]  sdata;
    logic         mvalid;
    logic         mready;
    logic [135:0] mdata;
    logic [1:0]   mode;
    logic [43:0]  ppn;
    logic         flush;
    logic         busy;
    logic [15:0]  fcount;

    int errors = 0;
    int checks = 0;

    decode_stage dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .decode_slave_valid_i  (svalid),
        .decode_slave_ready_o  (sready),
        .decode_slave_data_i   (sdata),
        .decode_master_valid_o (mvalid),
        .decode_master_ready_i (mready),
        .decode_master_data_o  (mdata),
        .mmpt_mode_i           (mode),
        .mmpt_ppn_i            (ppn),
        .decode_ctrl_flush_i   (flush),
        .decode_ctrl_busy_o    (busy),
        .decode_fault_count_o  (fcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [43:0]  ppn;
        logic [1:0]   acc;
        logic [63:0]  pa;
        logic [135:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [135:0] mk(
        input logic [1:0]  c,
        input logic        f,
        input logic        b,
        input logic [1:0]  lv,
        input logic [1:0]  ac,
        input logic [63:0] rt,
        input logic [63:0] pa
    );
        return {c, f, b, lv, ac, rt, pa};
    endfunction

    task automatic chk(input string name, input logic [135:0] act,
                       input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [135:0] ea;
    logic [135:0] eb;
    logic [135:0] ed;
    logic [135:0] ee;

    initial begin
        vecs[0]  = '{2'b01, 44'h1, 2'b00, 64'h0000_0400_0000_1000,
                     mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b00, 64'h1800,
                        64'h0000_0400_0000_1000)};
        vecs[1]  = '{2'b01, 44'h1, 2'b01, 64'h0000_0004_0000_1000,
                     mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b01, 64'h1008,
                        64'h0000_0004_0000_1000)};
        vecs[2]  = '{2'b10, 44'hABC, 2'b10, 64'h000F_F800_0000_0000,
                     mk(2'b00, 1'b0, 1'b0, 2'd3, 2'b10, 64'hABCFF8,
                        64'h000F_F800_0000_0000)};
        vecs[3]  = '{2'b10, 44'h1, 2'b00, 64'h0010_0000_0000_0000,
                     mk(2'b01, 1'b1, 1'b0, 2'd0, 2'b00, 64'h0,
                        64'h0010_0000_0000_0000)};
        vecs[4]  = '{2'b01, 44'h1, 2'b00, 64'h0000_1000_0000_0000,
                     mk(2'b01, 1'b1, 1'b0, 2'd0, 2'b00, 64'h0,
                        64'h0000_1000_0000_0000)};
        vecs[5]  = '{2'b11, 44'h1, 2'b11, 64'h1234,
                     mk(2'b10, 1'b1, 1'b0, 2'd0, 2'b11, 64'h0,
                        64'h1234)};
        vecs[6]  = '{2'b01, 44'h1, 2'b11, 64'h1000,
                     mk(2'b11, 1'b1, 1'b0, 2'd0, 2'b11, 64'h0,
                        64'h1000)};
        vecs[7]  = '{2'b00, 44'h55, 2'b00, 64'hDEAD_0000,
                     mk(2'b00, 1'b0, 1'b1, 2'd0, 2'b00, 64'h0,
                        64'hDEAD_0000)};
        vecs[8]  = '{2'b01, 44'hFFF_FFFF_FFFF, 2'b01,
                     64'h0000_07FC_0000_0000,
                     mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b01,
                        64'h00FF_FFFF_FFFF_FFF8,
                        64'h0000_07FC_0000_0000)};
        vecs[9]  = '{2'b01, 44'h1, 2'b00, 64'h0000_0800_0000_0000,
                     mk(2'b01, 1'b1, 1'b0, 2'd0, 2'b00, 64'h0,
                        64'h0000_0800_0000_0000)};
        vecs[10] = '{2'b11, 44'h1, 2'b00, 64'hFFFF_0000_0000_0000,
                     mk(2'b10, 1'b1, 1'b0, 2'd0, 2'b00, 64'h0,
                        64'hFFFF_0000_0000_0000)};
        vecs[11] = '{2'b01, 44'h1, 2'b11, 64'h0000_0800_0000_0000,
                     mk(2'b11, 1'b1, 1'b0, 2'd0, 2'b11, 64'h0,
                        64'h0000_0800_0000_0000)};

        rst_ni = 1'b0;
        svalid = 1'b0;
        sdata  = '0;
        mready = 1'b0;
        mode   = 2'b00;
        ppn    = '0;
        flush  = 1'b0;

        // reset state
        #12;
        chk("rst_valid", mvalid, 0);
        chk("rst_ready", sready, 0);
        chk("rst_data", mdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fcount, 0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("rel_ready_pre_edge", sready, 0);
        tick();
        chk("rel_ready", sready, 1);
        chk("rel_valid", mvalid, 0);

        // table: one request at a time, sink always ready
        for (int i = 0; i < 12; i++) begin
            mode   = vecs[i].mode;
            ppn    = vecs[i].ppn;
            sdata  = {vecs[i].acc, vecs[i].pa};
            svalid = 1'b1;
            mready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_ready", i), sready, 1);
            tick();
            svalid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), mvalid, 1);
            chk($sformatf("tbl%0d_data", i), mdata, vecs[i].exp);
            tick();
            chk($sformatf("tbl%0d_drained", i), mvalid, 0);
        end
        chk("tbl_fault_count", fcount, 7);

        // CSR change after acceptance
        mready = 1'b0;
        mode   = 2'b01;
        ppn    = 44'h1;
        sdata  = {2'b00, 64'h1000};
        svalid = 1'b1;
        tick();
        svalid = 1'b0;
        ppn    = 44'h7;
        mode   = 2'b00;
        tick();
        chk("csr_valid", mvalid, 1);
        chk("csr_data", mdata,
            mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b00, 64'h1000, 64'h1000));
        mready = 1'b1;
        tick();
        chk("csr_drained", mvalid, 0);

        // backpressure: three back-to-back, two accepted
        mready = 1'b0;
        mode   = 2'b01;
        ppn    = 44'h2;
        ea = mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b00, 64'h2000, 64'h1000);
        eb = mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b00, 64'h2000, 64'h2000);
        svalid = 1'b1;
        sdata  = {2'b00, 64'h1000};
        #1;
        chk("bp_ready1", sready, 1);
        tick();
        sdata = {2'b00, 64'h2000};
        #1;
        chk("bp_ready2", sready, 1);
        tick();
        sdata = {2'b00, 64'h3000};
        #1;
        chk("bp_ready3", sready, 0);
        chk("bp_busy", busy, 1);
        tick();
        svalid = 1'b0;
        chk("bp_stall_valid", mvalid, 1);
        chk("bp_stall_data1", mdata, ea);
        tick();
        chk("bp_stall_data2", mdata, ea);
        chk("bp_stall_ready", sready, 0);
        mready = 1'b1;
        tick();
        chk("bp_second_valid", mvalid, 1);
        chk("bp_second_data", mdata, eb);
        chk("bp_ready_again", sready, 1);
        tick();
        chk("bp_empty_valid", mvalid, 0);
        chk("bp_empty_busy", busy, 0);

        // accept and consume together with skid empty
        ed = mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b00, 64'h2000, 64'h4000);
        ee = mk(2'b00, 1'b0, 1'b0, 2'd2, 2'b00, 64'h2000, 64'h5000);
        svalid = 1'b1;
        sdata  = {2'b00, 64'h4000};
        tick();
        sdata = {2'b00, 64'h5000};
        chk("sim_first", mdata, ed);
        tick();
        svalid = 1'b0;
        chk("sim_second", mdata, ee);
        chk("sim_ready", sready, 1);
        tick();
        chk("sim_drained", mvalid, 0);
        chk("sim_busy", busy, 0);

        // flush with two entries held and a request pending
        mready = 1'b0;
        svalid = 1'b1;
        sdata  = {2'b00, 64'h1000};
        tick();
        sdata = {2'b00, 64'h2000};
        tick();
        sdata = {2'b00, 64'h3000};
        flush = 1'b1;
        #1;
        chk("fl_ready", sready, 0);
        chk("fl_busy_pre", busy, 1);
        tick();
        flush  = 1'b0;
        svalid = 1'b0;
        chk("fl_valid", mvalid, 0);
        chk("fl_busy", busy, 0);
        tick();
        chk("fl_not_taken", busy, 0);
        chk("fl_count_kept", fcount, 7);

        // flush overrides accept into an empty stage
        svalid = 1'b1;
        sdata  = {2'b00, 64'h1000};
        flush  = 1'b1;
        #1;
        chk("fl2_ready", sready, 0);
        tick();
        flush  = 1'b0;
        svalid = 1'b0;
        chk("fl2_busy", busy, 0);

        // reset in the middle of a stalled stream
        svalid = 1'b1;
        sdata  = {2'b00, 64'h1000};
        tick();
        sdata = {2'b00, 64'h2000};
        tick();
        svalid = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mr_valid", mvalid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_data", mdata, 0);
        chk("mr_count", fcount, 0);
        chk("mr_ready", sready, 0);
        tick();
        rst_ni = 1'b1;
        mready = 1'b1;
        tick();
        chk("mr_ready_after", sready, 1);
        chk("mr_valid_after", mvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
